spi_slave_cfg: RTL and testbench
================================

# spi_slave_cfg

Parametrised SPI slave used by the NPU host interface. It supports all four SPI modes, a configurable word width and frame size, synchronised pad inputs, and valid/ready handshakes on both transmit and receive. A word of NPU_DATA_WIDTH bits is carried as one or more SS-low frames of FRAME_BITS bits each. It sits between the SPI pads and the NPU controller and input FIFO.

## Interface
- NPU_DATA_WIDTH, 16: word width; must be a multiple of FRAME_BITS.
- FRAME_BITS, 8: bits per SS-low frame, ≥2.
- SYNC_STAGES, 2: synchroniser depth on spi_ss/spi_sclk/spi_mosi, ≥2.
- clk  input  1  system clock; f_clk ≥ 8 × f_sclk.
- reset_b  input  1  reset; one clock; reset is asynchronous and active-low.
- spi_ss  input  1  slave select, active-low, asynchronous pad.
- spi_sclk  input  1  SPI clock, asynchronous pad.
- spi_mosi  input  1  serial data in.
- spi_miso  output  1  serial data out, MSB first; 0 while idle.
- spi_mode  input  2  {CPOL,CPHA}; latched at word start.
- tx_data  input  NPU_DATA_WIDTH  word to transmit.
- tx_valid  input  1  tx_data available.
- tx_ready  output  1  one-cycle pulse: tx_data consumed.
- tx_underrun  output  1  one-cycle pulse: word started with no tx_valid.
- rx_data  output  NPU_DATA_WIDTH  last received word.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
- rx_overrun  output  1  one-cycle pulse: unconsumed word overwritten.
- frame_error  output  1  one-cycle pulse: SS rose off a frame boundary.
- word_done  output  1  one-cycle pulse: full word received.

## Operation
- Synchronisers: SYNC_STAGES flops per input. Edge detectors on the synchronised sclk and ss produce single-cycle pulses.
- Edges: leading = rising if CPOL=0, else falling. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- FSM states: IDLE, SHIFT, PAUSE, DONE.
  - IDLE → SHIFT on synchronised ss low. At this transition:
    - latch spi_mode;
    - clear the bit counter (width clog2(NPU_DATA_WIDTH+1));
    - load the tx shift register from tx_data and pulse tx_ready if tx_valid;
    - otherwise load all-zero and pulse tx_underrun.
  - SHIFT: each sample edge shifts mosi into the LSB of the rx shift register and increments the bit counter. Each shift edge shifts the tx register left. When CPHA=1, the first shift edge of a word is ignored.
  - SHIFT, ss rises:
    - count == NPU_DATA_WIDTH → DONE;
    - count a non-zero multiple of FRAME_BITS and < NPU_DATA_WIDTH → PAUSE;
    - any other count → pulse frame_error, discard the word, → IDLE.
  - PAUSE → SHIFT on ss low; counters and shift registers are retained, and no tx reload happens. Sclk edges in PAUSE are ignored.
  - DONE → IDLE unconditionally. In DONE: rx_data ← rx shift register, rx_valid ← 1, word_done = 1.
- Sample edges beyond NPU_DATA_WIDTH within a word are ignored; the counter saturates.
- spi_miso = tx shift register MSB while in SHIFT/PAUSE, else 0.
- Handshake: rx_valid clears on rx_valid & rx_ready.
  - DONE with rx_valid=1 and no rx_ready that cycle: rx_overrun pulses and data is overwritten.
  - DONE with rx_ready in the same cycle: no overrun; rx_valid stays 1 and holds the new data.
- spi_mode changes during SHIFT/PAUSE have no effect until the next IDLE → SHIFT.

## Timing
- Pin-to-edge-pulse latency is SYNC_STAGES+1 clk cycles. Shift and sample actions happen in the cycle of the pulse.
- tx_ready/tx_underrun assert in the cycle pstate goes IDLE → SHIFT. MSB appears on spi_miso the following cycle.
- DONE lasts exactly 1 cycle. word_done is high in DONE. rx_valid/rx_data update the cycle after DONE.
- frame_error pulses in the cycle the ss-rise pulse is seen in SHIFT.
- Reset (asynchronous, any state, including mid-word): FSM = IDLE, synchronisers reset to ss=1, sclk=CPOL-independent 0, all shift registers/counters = 0, all outputs = 0. The first word after reset waits for a fresh ss fall.

## Test plan
- Mode 0, 16/8: two frames carry MOSI 0xA55A with tx_data=0x1234 → MISO bits 0x1234 MSB-first; rx_data=0xA55A, rx_valid=1; word_done and tx_ready each pulse once.
- Mode 3 and mode 1, same traffic → identical rx_data/MISO. Changing spi_mode between frames has no effect.
- Two words received with rx_ready=0 → rx_overrun pulses once and rx_data holds the second word. Repeat with rx_ready=1 in the DONE cycle → no overrun.
- SS rises after 5 sclk edges → frame_error pulse, rx_valid unchanged, FSM returns to IDLE; the next 16-bit word is received correctly.
- tx_valid=0 at word start → tx_underrun pulse, MISO all zeros, rx path still correct.
- reset_b low mid-word (bit 9) → all outputs 0 immediately; after release, a full word 0x00FF is received correctly.

Source files
------------

// File: rtl/spi_slave_cfg.sv
// SPI slave for the NPU host interface: all four SPI modes, words split over
// one or more SS-low frames, synchronised pad inputs and valid/ready handshakes.
module spi_slave_cfg #(
   parameter int unsigned NPU_DATA_WIDTH = 16,
   parameter int unsigned FRAME_BITS     = 8,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic                      clk,
   input  logic                      reset_b,
   input  logic                      spi_ss,
   input  logic                      spi_sclk,
   input  logic                      spi_mosi,
   output logic                      spi_miso,
   input  logic [1:0]                spi_mode,
   input  logic [NPU_DATA_WIDTH-1:0] tx_data,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   output logic                      tx_underrun,
   output logic [NPU_DATA_WIDTH-1:0] rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic                      rx_overrun,
   output logic                      frame_error,
   output logic                      word_done
);
   localparam int unsigned W     = NPU_DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(NPU_DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, PAUSE, DONE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   ss_prev;
   logic                   sclk_prev;
   logic                   cpol_q;
   logic                   cpha_q;
   logic                   first_shift;
   logic [CNT_W-1:0]       bit_cnt;
   logic [W-1:0]           tx_shift;
   logic [W-1:0]           rx_shift;

   logic ss_s, sclk_s, mosi_s;
   logic ss_fall_c, ss_rise_c, sclk_rise_c, sclk_fall_c;
   logic lead_c, trail_c, sample_c, shift_c, frame_bound_c;

   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   assign ss_fall_c   = ss_prev & ~ss_s;
   assign ss_rise_c   = ~ss_prev & ss_s;
   assign sclk_rise_c = ~sclk_prev & sclk_s;
   assign sclk_fall_c = sclk_prev & ~sclk_s;

   // Edge roles follow the mode latched at word start, not the live input
   assign lead_c   = cpol_q ? sclk_fall_c : sclk_rise_c;
   assign trail_c  = cpol_q ? sclk_rise_c : sclk_fall_c;
   assign sample_c = cpha_q ? trail_c : lead_c;
   assign shift_c  = cpha_q ? lead_c : trail_c;

   assign frame_bound_c = (bit_cnt != '0) &&
                          ((bit_cnt % CNT_W'(FRAME_BITS)) == '0) &&
                          (bit_cnt < CNT_W'(W));

   // Pad synchronisers and edge-detector history
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_prev   <= 1'b1;
         sclk_prev <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         ss_prev   <= ss_s;
         sclk_prev <= sclk_s;
      end
   end

   // Word FSM with registered outputs
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state       <= IDLE;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         first_shift <= 1'b0;
         bit_cnt     <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         spi_miso    <= 1'b0;
         tx_ready    <= 1'b0;
         tx_underrun <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_overrun  <= 1'b0;
         frame_error <= 1'b0;
         word_done   <= 1'b0;
      end else begin
         tx_ready    <= 1'b0;
         tx_underrun <= 1'b0;
         rx_overrun  <= 1'b0;
         frame_error <= 1'b0;
         word_done   <= 1'b0;
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (ss_fall_c) begin
                  state       <= SHIFT;
                  cpol_q      <= spi_mode[1];
                  cpha_q      <= spi_mode[0];
                  first_shift <= 1'b1;
                  bit_cnt     <= '0;
                  if (tx_valid) begin
                     tx_shift <= tx_data;
                     spi_miso <= tx_data[W-1];
                     tx_ready <= 1'b1;
                  end else begin
                     tx_shift    <= '0;
                     spi_miso    <= 1'b0;
                     tx_underrun <= 1'b1;
                  end
               end
            end

            SHIFT: begin
               if (ss_rise_c) begin
                  if (bit_cnt == CNT_W'(W)) begin
                     state     <= DONE;
                     word_done <= 1'b1;
                     spi_miso  <= 1'b0;
                  end else if (frame_bound_c) begin
                     state <= PAUSE;
                  end else begin
                     state       <= IDLE;
                     frame_error <= 1'b1;
                     spi_miso    <= 1'b0;
                  end
               end else begin
                  if (sample_c && (bit_cnt < CNT_W'(W))) begin
                     rx_shift <= {rx_shift[W-2:0], mosi_s};
                     bit_cnt  <= bit_cnt + CNT_W'(1);
                  end
                  // With CPHA=1 the MSB is already on the pin before the first leading edge
                  if (shift_c) begin
                     if (cpha_q && first_shift) begin
                        first_shift <= 1'b0;
                     end else begin
                        tx_shift <= {tx_shift[W-2:0], 1'b0};
                        spi_miso <= tx_shift[W-2];
                     end
                  end
               end
            end

            PAUSE: begin
               if (ss_fall_c) begin
                  state <= SHIFT;
               end
            end

            DONE: begin
               state    <= IDLE;
               rx_data  <= rx_shift;
               rx_valid <= 1'b1;
               if (rx_valid && !rx_ready) begin
                  rx_overrun <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Directed bench for spi_slave_cfg: modes, handshakes, frame errors, underrun, reset.
module tb_spi_slave_cfg;
   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        reset_b = 1'b0;
   logic        spi_ss = 1'b1;
   logic        spi_sclk = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic [1:0]  spi_mode = 2'b00;
   logic [15:0] tx_data = 16'h0000;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic        tx_underrun;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic        rx_overrun;
   logic        frame_error;
   logic        word_done;

   int checks = 0;
   int passed = 0;
   int n_txr = 0, n_und = 0, n_ovr = 0, n_ferr = 0, n_done = 0;
   logic [15:0] mosi_word;
   logic [15:0] miso_cap;

   spi_slave_cfg #(.NPU_DATA_WIDTH(16), .FRAME_BITS(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_b(reset_b), .spi_ss(spi_ss), .spi_sclk(spi_sclk),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_mode(spi_mode),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .rx_overrun(rx_overrun), .frame_error(frame_error),
      .word_done(word_done)
   );

   always #5 clk = ~clk;

   // Pulse counters; tests look at deltas
   always @(negedge clk) begin
      if (tx_ready)    n_txr++;
      if (tx_underrun) n_und++;
      if (rx_overrun)  n_ovr++;
      if (frame_error) n_ferr++;
      if (word_done)   n_done++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_frame(input logic cpol, input logic cpha, input int first,
                            input int n, input bit release_ss);
      spi_sclk = cpol;
      wait_clk(6);
      spi_ss = 1'b0;
      wait_clk(HALF);
      for (int i = first; i < first + n; i++) begin
         if (!cpha) begin
            spi_mosi = mosi_word[15-i];
            wait_clk(HALF);
            miso_cap[15-i] = spi_miso;
            spi_sclk = ~cpol;
            wait_clk(HALF);
            spi_sclk = cpol;
         end else begin
            wait_clk(HALF);
            spi_sclk = ~cpol;
            spi_mosi = mosi_word[15-i];
            wait_clk(HALF);
            miso_cap[15-i] = spi_miso;
            spi_sclk = cpol;
         end
      end
      if (release_ss) begin
         wait_clk(HALF);
         spi_ss = 1'b1;
      end
   endtask

   task automatic send_word(input logic cpol, input logic cpha, input logic [15:0] w);
      mosi_word = w;
      miso_cap  = 16'h0000;
      spi_frame(cpol, cpha, 0, 8, 1'b1);
      wait_clk(10);
      spi_frame(cpol, cpha, 8, 8, 1'b1);
      wait_clk(20);
   endtask

   task automatic consume();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      wait_clk(3);
      reset_b = 1'b1;
      wait_clk(4);
      checks++; if (rx_data !== 16'h0000) $display("FAIL reset_rx_data: got %h expected %h", rx_data, 16'h0000); else passed++;
      checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected %b", rx_valid, 1'b0); else passed++;
      checks++; if (spi_miso !== 1'b0) $display("FAIL reset_miso: got %b expected %b", spi_miso, 1'b0); else passed++;
      checks++;
      if ({tx_ready, tx_underrun, rx_overrun, frame_error, word_done} !== 5'b00000)
         $display("FAIL reset_pulses: got %b expected %b",
                  {tx_ready, tx_underrun, rx_overrun, frame_error, word_done}, 5'b00000);
      else passed++;
   endtask

   task automatic test_mode0();
      int t0 = n_txr, d0 = n_done, u0 = n_und;
      spi_mode = 2'b00; tx_data = 16'h1234; tx_valid = 1'b1;
      send_word(1'b0, 1'b0, 16'hA55A);
      checks++; if (rx_data !== 16'hA55A) $display("FAIL mode0_rx_data: got %h expected %h", rx_data, 16'hA55A); else passed++;
      checks++; if (rx_valid !== 1'b1) $display("FAIL mode0_rx_valid: got %b expected %b", rx_valid, 1'b1); else passed++;
      checks++; if (miso_cap !== 16'h1234) $display("FAIL mode0_miso: got %h expected %h", miso_cap, 16'h1234); else passed++;
      checks++; if (n_done - d0 !== 1) $display("FAIL mode0_word_done_count: got %0d expected %0d", n_done - d0, 1); else passed++;
      checks++; if (n_txr - t0 !== 1) $display("FAIL mode0_tx_ready_count: got %0d expected %0d", n_txr - t0, 1); else passed++;
      checks++; if (n_und - u0 !== 0) $display("FAIL mode0_underrun_count: got %0d expected %0d", n_und - u0, 0); else passed++;
      consume();
      checks++; if (rx_valid !== 1'b0) $display("FAIL mode0_rx_consumed: got %b expected %b", rx_valid, 1'b0); else passed++;
   endtask

   task automatic test_mode_cpha(input logic cpol, input logic cpha, input logic [1:0] other);
      spi_mode = {cpol, cpha}; tx_data = 16'h1234; tx_valid = 1'b1;
      mosi_word = 16'hA55A;
      miso_cap  = 16'h0000;
      spi_frame(cpol, cpha, 0, 8, 1'b1);
      wait_clk(10);
      spi_mode = other;
      spi_frame(cpol, cpha, 8, 8, 1'b1);
      wait_clk(20);
      checks++; if (rx_data !== 16'hA55A) $display("FAIL mode%0d_rx_data: got %h expected %h", {cpol, cpha}, rx_data, 16'hA55A); else passed++;
      checks++; if (miso_cap !== 16'h1234) $display("FAIL mode%0d_miso: got %h expected %h", {cpol, cpha}, miso_cap, 16'h1234); else passed++;
      checks++; if (rx_valid !== 1'b1) $display("FAIL mode%0d_rx_valid: got %b expected %b", {cpol, cpha}, rx_valid, 1'b1); else passed++;
      consume();
   endtask

   task automatic test_overrun();
      int o0 = n_ovr;
      bit seen = 1'b0;
      spi_mode = 2'b00; tx_data = 16'h0F0F; tx_valid = 1'b1;
      send_word(1'b0, 1'b0, 16'h1111);
      send_word(1'b0, 1'b0, 16'h2222);
      checks++; if (n_ovr - o0 !== 1) $display("FAIL overrun_count: got %0d expected %0d", n_ovr - o0, 1); else passed++;
      checks++; if (rx_data !== 16'h2222) $display("FAIL overrun_rx_data: got %h expected %h", rx_data, 16'h2222); else passed++;
      checks++; if (rx_valid !== 1'b1) $display("FAIL overrun_rx_valid: got %b expected %b", rx_valid, 1'b1); else passed++;
      // Third word with rx_ready raised only during the DONE cycle
      o0 = n_ovr;
      mosi_word = 16'h3333;
      spi_frame(1'b0, 1'b0, 0, 8, 1'b1);
      wait_clk(10);
      spi_frame(1'b0, 1'b0, 8, 8, 1'b1);
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (word_done) seen = 1'b1;
      end
      checks++; if (!seen) $display("FAIL done_cycle_word_done: got %b expected %b", seen, 1'b1); else passed++;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      wait_clk(5);
      checks++; if (n_ovr - o0 !== 0) $display("FAIL done_cycle_overrun: got %0d expected %0d", n_ovr - o0, 0); else passed++;
      checks++; if (rx_valid !== 1'b1) $display("FAIL done_cycle_rx_valid: got %b expected %b", rx_valid, 1'b1); else passed++;
      checks++; if (rx_data !== 16'h3333) $display("FAIL done_cycle_rx_data: got %h expected %h", rx_data, 16'h3333); else passed++;
   endtask

   task automatic test_frame_error();
      int f0 = n_ferr, d0 = n_done, t0;
      spi_mode = 2'b00; tx_data = 16'h1234; tx_valid = 1'b1;
      mosi_word = 16'hFFFF;
      spi_frame(1'b0, 1'b0, 0, 5, 1'b1);
      wait_clk(20);
      checks++; if (n_ferr - f0 !== 1) $display("FAIL ferr_count: got %0d expected %0d", n_ferr - f0, 1); else passed++;
      checks++; if (rx_valid !== 1'b1) $display("FAIL ferr_rx_valid: got %b expected %b", rx_valid, 1'b1); else passed++;
      checks++; if (rx_data !== 16'h3333) $display("FAIL ferr_rx_data: got %h expected %h", rx_data, 16'h3333); else passed++;
      checks++; if (n_done - d0 !== 0) $display("FAIL ferr_word_done: got %0d expected %0d", n_done - d0, 0); else passed++;
      consume();
      t0 = n_txr;
      send_word(1'b0, 1'b0, 16'h5AA5);
      checks++; if (rx_data !== 16'h5AA5) $display("FAIL ferr_next_rx_data: got %h expected %h", rx_data, 16'h5AA5); else passed++;
      checks++; if (n_txr - t0 !== 1) $display("FAIL ferr_next_tx_ready: got %0d expected %0d", n_txr - t0, 1); else passed++;
      checks++; if (miso_cap !== 16'h1234) $display("FAIL ferr_next_miso: got %h expected %h", miso_cap, 16'h1234); else passed++;
      consume();
   endtask

   task automatic test_underrun();
      int u0 = n_und, t0 = n_txr;
      spi_mode = 2'b00; tx_data = 16'hFFFF; tx_valid = 1'b0;
      send_word(1'b0, 1'b0, 16'hC3C3);
      checks++; if (n_und - u0 !== 1) $display("FAIL underrun_count: got %0d expected %0d", n_und - u0, 1); else passed++;
      checks++; if (n_txr - t0 !== 0) $display("FAIL underrun_tx_ready: got %0d expected %0d", n_txr - t0, 0); else passed++;
      checks++; if (miso_cap !== 16'h0000) $display("FAIL underrun_miso: got %h expected %h", miso_cap, 16'h0000); else passed++;
      checks++; if (rx_data !== 16'hC3C3) $display("FAIL underrun_rx_data: got %h expected %h", rx_data, 16'hC3C3); else passed++;
   endtask

   task automatic test_reset_mid();
      spi_mode = 2'b00; tx_data = 16'hBEEF; tx_valid = 1'b1;
      mosi_word = 16'hFFFF;
      spi_frame(1'b0, 1'b0, 0, 9, 1'b0);
      reset_b = 1'b0;
      #1;
      checks++; if (rx_valid !== 1'b0) $display("FAIL rstmid_rx_valid: got %b expected %b", rx_valid, 1'b0); else passed++;
      checks++; if (rx_data !== 16'h0000) $display("FAIL rstmid_rx_data: got %h expected %h", rx_data, 16'h0000); else passed++;
      checks++;
      if ({spi_miso, tx_ready, tx_underrun, rx_overrun, frame_error, word_done} !== 6'b000000)
         $display("FAIL rstmid_outputs: got %b expected %b",
                  {spi_miso, tx_ready, tx_underrun, rx_overrun, frame_error, word_done}, 6'b000000);
      else passed++;
      wait_clk(2);
      spi_ss = 1'b1; spi_sclk = 1'b0;
      wait_clk(2);
      reset_b = 1'b1;
      wait_clk(6);
      send_word(1'b0, 1'b0, 16'h00FF);
      checks++; if (rx_data !== 16'h00FF) $display("FAIL rstmid_next_rx_data: got %h expected %h", rx_data, 16'h00FF); else passed++;
      checks++; if (rx_valid !== 1'b1) $display("FAIL rstmid_next_rx_valid: got %b expected %b", rx_valid, 1'b1); else passed++;
      checks++; if (miso_cap !== 16'hBEEF) $display("FAIL rstmid_next_miso: got %h expected %h", miso_cap, 16'hBEEF); else passed++;
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode_cpha(1'b1, 1'b1, 2'b00);
      test_mode_cpha(1'b0, 1'b1, 2'b11);
      test_overrun();
      test_frame_error();
      test_underrun();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
